// File: rtl/pwm_capture.sv
// PWM input capture: times high and period of pwm_in in prescaler ticks and
// recovers duty = floor(high*2^R/period) with a serial restoring divider.
//   state     | meaning
//   WAIT_EDGE | idle, counters at 0, first rise starts a period
//   MEASURE   | counting ticks of the current period
//   DIVIDE    | R+1 divider steps, next period counted in parallel
module pwm_capture #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  input  logic                  pwm_in,
  output logic [R:0]            duty,
  output logic [CNT_BITS-1:0]   high_count,
  output logic [CNT_BITS-1:0]   period_count,
  output logic                  valid,
  output logic                  timeout,
  output logic                  overrun
);

  localparam int SW = $clog2(R + 1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_BITS-1:0]   CNT_ONE   = CNT_BITS'(1);
  localparam logic [TIMER_BITS-1:0] TMR_ONE   = TIMER_BITS'(1);
  localparam logic [SW-1:0]         STEP_LAST = SW'(R);
  localparam logic [SW-1:0]         STEP_ONE  = SW'(1);
  localparam logic [R:0]            DUTY_FULL = {1'b1, {R{1'b0}}};

  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, DIVIDE} state_t;

  state_t                state_q;
  logic                  meta_q, sync_q, hist_q;
  logic [TIMER_BITS-1:0] presc_q, fv_q;
  logic [CNT_BITS-1:0]   period_q, high_q, div_q, hi_op_q;
  logic [CNT_BITS:0]     rem_q;
  logic [R-1:0]          quo_q;
  logic [SW-1:0]         step_q;
  logic [R:0]            duty_q;
  logic [CNT_BITS-1:0]   high_count_q, period_count_q;
  logic                  valid_q, timeout_q, overrun_q;

  logic                  tick, rise, at_limit, q_bit;
  logic [CNT_BITS-1:0]   period_d, high_d, restart_d;
  logic [CNT_BITS:0]     rem_diff, rem_d;
  logic [R:0]            quo_d;

  always_comb begin
    tick      = enable && (presc_q == fv_q);
    rise      = sync_q && !hist_q;
    // a tick coinciding with the rise is the first tick of the new period
    restart_d = tick ? CNT_ONE : '0;
    period_d  = tick ? period_q + CNT_ONE : period_q;
    high_d    = (tick && sync_q) ? high_q + CNT_ONE : high_q;
    at_limit  = (period_q == CNT_MAX) || (tick && (period_q == CNT_MAX - CNT_ONE));
    q_bit     = rem_q >= {1'b0, div_q};
    rem_diff  = rem_q - {1'b0, div_q};
    rem_d     = q_bit ? {rem_diff[CNT_BITS-1:0], 1'b0} : {rem_q[CNT_BITS-1:0], 1'b0};
    quo_d     = {quo_q, q_bit};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= pwm_in;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  // compare value only reloads at a wrap, so a new FINAL_VALUE never cuts a tick short
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      fv_q    <= '0;
    end else if (!enable || tick) begin
      presc_q <= '0;
      fv_q    <= FINAL_VALUE;
    end else begin
      presc_q <= presc_q + TMR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= WAIT_EDGE;
      period_q       <= '0;
      high_q         <= '0;
      div_q          <= '0;
      hi_op_q        <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      step_q         <= '0;
      duty_q         <= '0;
      high_count_q   <= '0;
      period_count_q <= '0;
      valid_q        <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      if (!enable) begin
        state_q  <= WAIT_EDGE;
        period_q <= '0;
        high_q   <= '0;
      end else begin
        case (state_q)
          WAIT_EDGE: begin
            period_q <= '0;
            high_q   <= '0;
            if (rise) begin
              state_q  <= MEASURE;
              period_q <= restart_d;
              high_q   <= restart_d;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q <= restart_d;
              high_q   <= restart_d;
              if (period_q == '0) begin
                overrun_q <= 1'b1;
              end else begin
                div_q   <= period_q;
                hi_op_q <= high_q;
                rem_q   <= {1'b0, high_q};
                quo_q   <= '0;
                step_q  <= '0;
                state_q <= DIVIDE;
              end
            end else if (at_limit) begin
              duty_q         <= sync_q ? DUTY_FULL : '0;
              high_count_q   <= sync_q ? CNT_MAX : '0;
              period_count_q <= CNT_MAX;
              valid_q        <= 1'b1;
              timeout_q      <= 1'b1;
              period_q       <= '0;
              high_q         <= '0;
              state_q        <= WAIT_EDGE;
            end else begin
              period_q <= period_d;
              high_q   <= high_d;
            end
          end
          DIVIDE: begin
            if (rise) begin
              overrun_q <= 1'b1;
              period_q  <= restart_d;
              high_q    <= restart_d;
            end else begin
              period_q <= period_d;
              high_q   <= high_d;
            end
            rem_q  <= rem_d;
            quo_q  <= quo_d[R-1:0];
            step_q <= step_q + STEP_ONE;
            if (step_q == STEP_LAST) begin
              duty_q         <= quo_d;
              high_count_q   <= hi_op_q;
              period_count_q <= div_q;
              valid_q        <= 1'b1;
              timeout_q      <= 1'b0;
              state_q        <= MEASURE;
            end
          end
          default: state_q <= WAIT_EDGE;
        endcase
      end
    end
  end

  assign duty         = duty_q;
  assign high_count   = high_count_q;
  assign period_count = period_count_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: random PWM bursts against an
// edge-level reference (high/period arithmetic), plus overrun, reset, enable and timeout cases.
module tb_pwm_capture;

  localparam int R    = 8;
  localparam int CW   = 12;
  localparam int MAXC = (1 << CW) - 1;
  localparam int FULL = 1 << R;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    fv = '0;
  logic          pwm = 1'b0;
  logic [R:0]    duty;
  logic [CW-1:0] high_count, period_count;
  logic          valid, timeout, overrun;

  pwm_capture #(.R(R), .TIMER_BITS(8), .CNT_BITS(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .FINAL_VALUE(fv), .pwm_in(pwm),
    .duty(duty), .high_count(high_count), .period_count(period_count),
    .valid(valid), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int duty; int hi; int per; int to;} exp_t;
  exp_t q[$];
  exp_t last_e;

  int n_checks = 0, n_pass = 0;
  int ovr_cnt = 0, nval = 0, cyc = 0, last_v = -1;
  bit ovr_mode = 1'b0;

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int l);
    pwm = 1'b1;
    cyc_wait(h);
    pwm = 1'b0;
    cyc_wait(l);
  endtask

  function automatic void expect_res(input int d, input int h, input int p, input int t);
    exp_t e;
    e.duty = d; e.hi = h; e.per = p; e.to = t;
    q.push_back(e);
  endfunction

  task automatic wait_empty(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      cyc_wait(1);
      n++;
    end
    chk("result_arrival", q.size(), 0);
  endtask

  // mode 0: fixed h/p clocks at tick=clk; 1: random at tick=clk; 2: random multiples of 4 at FINAL_VALUE=3
  task automatic burst(input int n, input int mode, input int fh, input int fp);
    int h, p, ht, pt;
    ovr_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) begin
        h = fh; p = fp; ht = h; pt = p;
      end else if (mode == 1) begin
        p = $urandom_range(300, 12); h = $urandom_range(p - 1, 1); ht = h; pt = p;
      end else begin
        pt = $urandom_range(75, 3); ht = $urandom_range(pt - 1, 1); p = 4 * pt; h = 4 * ht;
      end
      expect_res((ht * FULL) / pt, ht, pt, 0);
      drive(h, p - h);
    end
    drive(3, 20);
    enable = 1'b0;
    cyc_wait(10);
    chk("hold_duty", int'(duty), last_e.duty);
    chk("hold_high", int'(high_count), last_e.hi);
    chk("hold_period", int'(period_count), last_e.per);
    chk("pending_results", q.size(), 0);
    chk("no_overrun", ovr_cnt, 0);
    enable = 1'b1;
    cyc_wait(2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (overrun) ovr_cnt++;
    if (valid) begin
      if (ovr_mode) begin
        chk("ovr_duty", int'(duty), FULL / 2);
        chk("ovr_high", int'(high_count), 2);
        chk("ovr_period", int'(period_count), 4);
        if (last_v >= 0) chk("valid_spacing", int'((cyc - last_v) >= R + 2), 1);
        last_v = cyc;
        nval++;
      end else if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("duty", int'(duty), e.duty);
        chk("high_count", int'(high_count), e.hi);
        chk("period_count", int'(period_count), e.per);
        chk("timeout", int'(timeout), e.to);
        last_e = e;
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    last_e = '{0, 0, 0, 0};
    cyc_wait(3);
    chk("rst_duty", int'(duty), 0);
    chk("rst_high", int'(high_count), 0);
    chk("rst_period", int'(period_count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    cyc_wait(2);
    enable = 1'b1;
    cyc_wait(2);

    burst(3, 0, 64, 256);
    burst(8, 1, 0, 0);

    // 4-clock 50% input: divider is busy for most rises
    ovr_mode = 1'b1; nval = 0; last_v = -1; ovr_cnt = 0;
    repeat (16) drive(2, 2);
    cyc_wait(20);
    ovr_mode = 1'b0;
    chk("ovr_seen", int'(ovr_cnt > 0), 1);
    chk("ovr_valids", int'(nval >= 2), 1);
    enable = 1'b0;
    cyc_wait(2);
    enable = 1'b1;
    cyc_wait(2);
    burst(4, 1, 0, 0);

    enable = 1'b0; fv = 8'd3; cyc_wait(2); enable = 1'b1; cyc_wait(2);
    burst(8, 2, 0, 0);
    enable = 1'b0; fv = 8'd0; cyc_wait(2); enable = 1'b1; cyc_wait(2);

    // reset a few cycles into a division
    drive(20, 30);
    pwm = 1'b1;
    cyc_wait(6);
    reset_n = 1'b0;
    #1;
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_high", int'(high_count), 0);
    chk("midrst_period", int'(period_count), 0);
    chk("midrst_valid", int'(valid), 0);
    last_e = '{0, 0, 0, 0};
    cyc_wait(3);
    pwm = 1'b0;
    reset_n = 1'b1;
    cyc_wait(20);
    burst(4, 1, 0, 0);

    expect_res(FULL, MAXC, MAXC, 1);
    pwm = 1'b1;
    wait_empty(MAXC + 40);
    cyc_wait(5);
    chk("timeout_level", int'(timeout), 1);
    pwm = 1'b0;
    cyc_wait(5);
    expect_res(0, 0, MAXC, 1);
    drive(5, 0);
    wait_empty(MAXC + 40);
    cyc_wait(5);
    chk("timeout_level_low", int'(timeout), 1);
    burst(3, 1, 0, 0);
    chk("timeout_cleared", int'(timeout), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
